// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core and its result buffer.
package conv_pkg;

   localparam int unsigned CONV_DATAZ_W = 16;
   localparam int unsigned CONV_ADDRZ_W = 6;
   localparam int unsigned CONV_DEPTH   = 64;

   typedef enum logic [1:0] {
      RB_IDLE,
      RB_CAPTURE,
      RB_DRAIN
   } conv_rbuf_state_t;

endpackage

// File: rtl/conv_rbuf_mem.sv
// Result storage: register array with one write port and one async read port.
// Define CONV_RBUF_ZERO_FILL_EN to make never-written entries read back as zero.
module conv_rbuf_mem #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

`ifdef CONV_RBUF_ZERO_FILL_EN
   logic [DEPTH-1:0] r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_clr) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_waddr] <= 1'b1;
      end
   end

   always_comb begin
      o_rdata = r_valid[i_raddr] ? r_mem[i_raddr] : '0;
   end
`else
   logic w_unused_rst;
   logic w_unused_clr;

   assign w_unused_rst = rst_n;
   assign w_unused_clr = i_clr;

   always_comb begin
      o_rdata = r_mem[i_raddr];
   end
`endif

endmodule

// File: rtl/conv_result_buffer.sv
// Captures the convolution core's result writes and streams them out in address order.
// Optional zero-fill of unwritten holes via CONV_RBUF_ZERO_FILL_EN (see conv_rbuf_mem).
module conv_result_buffer
   import conv_pkg::*;
#(
   parameter int unsigned DATA_W = CONV_DATAZ_W,
   parameter int unsigned ADDR_W = CONV_ADDRZ_W,
   parameter int unsigned DEPTH  = CONV_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              done_i,
   input  logic              writeZ,
   input  logic [ADDR_W-1:0] memZ_addr,
   input  logic [DATA_W-1:0] dataZ,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] m_index,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              rb_busy,
   output logic [ADDR_W:0]   rb_count,
   output logic              rb_err,
   output logic              rb_drained
);

   conv_rbuf_state_t  r_state;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_max_addr;
   logic              r_have_data;
   logic [ADDR_W:0]   r_count;
   logic              r_err;
   logic              r_drained;

   logic              w_in_range;
   logic              w_we;
   logic              w_hs;
   logic [ADDR_W-1:0] w_new_max;
   logic [DATA_W-1:0] w_rdata;

   assign w_in_range = (32'(memZ_addr) < DEPTH);
   // A restart in the same cycle discards the write along with the rest of the set.
   assign w_we       = (r_state == RB_CAPTURE) && writeZ && w_in_range && !start_i;
   assign w_new_max  = (r_max_addr > memZ_addr) ? r_max_addr : memZ_addr;
   assign w_hs       = m_valid && m_ready;

   conv_rbuf_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (start_i),
      .i_we    (w_we),
      .i_waddr (memZ_addr),
      .i_wdata (dataZ),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RB_IDLE;
         r_rd_ptr    <= '0;
         r_max_addr  <= '0;
         r_have_data <= 1'b0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_drained   <= 1'b0;
      end else begin
         r_drained <= 1'b0;
         if (writeZ && ((r_state != RB_CAPTURE) || !w_in_range)) r_err <= 1'b1;

         if (start_i) begin
            r_state     <= RB_CAPTURE;
            r_have_data <= 1'b0;
            r_max_addr  <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
         end else begin
            case (r_state)
               RB_CAPTURE: begin
                  if (w_we) begin
                     r_have_data <= 1'b1;
                     r_max_addr  <= w_new_max;
                     r_count     <= {1'b0, w_new_max} + (ADDR_W+1)'(1);
                  end
                  if (done_i) begin
                     r_rd_ptr <= '0;
                     if (r_have_data || w_we) begin
                        r_state <= RB_DRAIN;
                     end else begin
                        r_state   <= RB_IDLE;
                        r_drained <= 1'b1;
                     end
                  end
               end
               RB_DRAIN: begin
                  if (w_hs) begin
                     if (m_last) begin
                        r_state   <= RB_IDLE;
                        r_drained <= 1'b1;
                     end else begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign m_valid    = (r_state == RB_DRAIN);
   assign m_data     = m_valid ? w_rdata : '0;
   assign m_index    = r_rd_ptr;
   assign m_last     = m_valid && (r_rd_ptr == r_max_addr);
   assign rb_busy    = (r_state != RB_IDLE);
   assign rb_count   = r_count;
   assign rb_err     = r_err;
   assign rb_drained = r_drained;

endmodule

// File: tb/tb_conv_result_buffer.sv
// Scoreboard bench for conv_result_buffer: directed captures, drains and restarts.
module tb_conv_result_buffer;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          done_i = 1'b0;
   logic          writeZ = 1'b0;
   logic [AW-1:0] memZ_addr = '0;
   logic [DW-1:0] dataZ = '0;
   logic [DW-1:0] m_data;
   logic [AW-1:0] m_index;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;
   logic          rb_busy;
   logic [AW:0]   rb_count;
   logic          rb_err;
   logic          rb_drained;

   conv_result_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .done_i     (done_i),
      .writeZ     (writeZ),
      .memZ_addr  (memZ_addr),
      .dataZ      (dataZ),
      .m_data     (m_data),
      .m_index    (m_index),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .rb_busy    (rb_busy),
      .rb_count   (rb_count),
      .rb_err     (rb_err),
      .rb_drained (rb_drained)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
      bit            care;
   } beat_t;

   beat_t         exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            hs_cyc = -10;
   bit            valid_seen = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_index;

`ifdef CONV_RBUF_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and checks hold under stall.
   always @(negedge clk) begin
      if (m_valid) valid_seen = 1'b1;
      if (prev_stall && m_valid) begin
         chk("hold_data", 32'(m_data), 32'(prev_data));
         chk("hold_index", 32'(m_index), 32'(prev_index));
      end
      if (m_valid && m_ready) begin
         hs_cyc = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(m_index), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_index", 32'(m_index), 32'(e.idx));
            chk("beat_last", 32'(m_last), 32'(e.last));
            if (e.care) chk("beat_data", 32'(m_data), 32'(e.data));
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_index = m_index;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic with_done);
      writeZ = 1'b1; memZ_addr = a; dataZ = d; done_i = with_done;
      tick();
      writeZ = 1'b0; done_i = 1'b0;
   endtask

   task automatic pulse_done();
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l, input bit c);
      beat_t e;
      e.idx = a; e.data = d; e.last = l; e.care = c;
      exp_q.push_back(e);
   endtask

   task automatic wait_drained(input string name, input int limit);
      bit got;
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (rb_drained) begin
            got = 1'b1;
            break;
         end
      end
      chk({name, "_drained_seen"}, 32'(got), 32'd1);
      if (got) chk({name, "_drained_lat"}, 32'(cyc), 32'(hs_cyc + 1));
      chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_busy", 32'(rb_busy), 32'd0);
      chk("rst_count", 32'(rb_count), 32'd0);
      chk("rst_drained", 32'(rb_drained), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Reset while draining must clear status asynchronously.
      pulse_start();
      write(6'd0, 16'h00AA, 1'b0);
      pulse_done();
      chk("pre_rst_valid", 32'(m_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(m_valid), 32'd0);
      chk("arst_busy", 32'(rb_busy), 32'd0);
      chk("arst_count", 32'(rb_count), 32'd0);
      chk("arst_err", 32'(rb_err), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic capture and drain.
      pulse_start();
      for (int unsigned i = 0; i < 5; i++) begin
         write(AW'(i), 16'h0010 + DW'(i), 1'b0);
         push(AW'(i), 16'h0010 + DW'(i), (i == 4), 1'b1);
      end
      chk("basic_count", 32'(rb_count), 32'd5);
      m_ready = 1'b1;
      pulse_done();
      wait_drained("basic", 20);
      chk("basic_count_after", 32'(rb_count), 32'd5);
      chk("basic_idle", 32'(rb_busy), 32'd0);
      m_ready = 1'b0;
      tick();

      // Backpressure with ready pattern 1,0,0,1.
      pulse_start();
      for (int unsigned i = 0; i < 5; i++) begin
         write(AW'(i), 16'h0010 + DW'(i), 1'b0);
         push(AW'(i), 16'h0010 + DW'(i), (i == 4), 1'b1);
      end
      pulse_done();
      begin
         bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
         bit got;
         got = 1'b0;
         for (int k = 0; k < 40; k++) begin
            m_ready = pat[k % 4];
            tick();
            if (rb_drained) begin
               got = 1'b1;
               break;
            end
         end
         chk("bp_drained_seen", 32'(got), 32'd1);
         chk("bp_drained_lat", 32'(cyc), 32'(hs_cyc + 1));
         chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);
      end
      m_ready = 1'b0;
      tick();

      // Write coincident with done is part of the set.
      pulse_start();
      for (int unsigned i = 0; i < 7; i++) push(AW'(i), 16'h0000, 1'b0, ZF);
      push(6'd7, 16'hBEEF, 1'b1, 1'b1);
      m_ready = 1'b1;
      write(6'd7, 16'hBEEF, 1'b1);
      chk("same_count", 32'(rb_count), 32'd8);
      wait_drained("same", 30);
      m_ready = 1'b0;
      tick();

      // Stray write sets sticky error; empty capture returns to idle.
      chk("err_clear", 32'(rb_err), 32'd0);
      write(6'd2, 16'hDEAD, 1'b0);
      chk("err_set", 32'(rb_err), 32'd1);
      valid_seen = 1'b0;
      pulse_start();
      pulse_done();
      chk("empty_drained", 32'(rb_drained), 32'd1);
      chk("empty_busy", 32'(rb_busy), 32'd0);
      chk("empty_count", 32'(rb_count), 32'd0);
      tick();
      chk("empty_drained_once", 32'(rb_drained), 32'd0);
      chk("empty_no_valid", 32'(valid_seen), 32'd0);
      chk("err_sticky", 32'(rb_err), 32'd1);

      // Holes between written addresses.
      pulse_start();
      write(6'd0, 16'h1111, 1'b0);
      write(6'd3, 16'h3333, 1'b0);
      push(6'd0, 16'h1111, 1'b0, 1'b1);
      push(6'd1, 16'h0000, 1'b0, ZF);
      push(6'd2, 16'h0000, 1'b0, ZF);
      push(6'd3, 16'h3333, 1'b1, 1'b1);
      chk("holes_count", 32'(rb_count), 32'd4);
      m_ready = 1'b1;
      pulse_done();
      wait_drained("holes", 20);
      m_ready = 1'b0;
      tick();

      // Restart in the middle of a drain.
      pulse_start();
      write(6'd0, 16'h1111, 1'b0);
      write(6'd3, 16'h3333, 1'b0);
      pulse_done();
      push(6'd0, 16'h1111, 1'b0, 1'b1);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("restart_pre_index", 32'(m_index), 32'd1);
      pulse_start();
      chk("restart_valid", 32'(m_valid), 32'd0);
      chk("restart_busy", 32'(rb_busy), 32'd1);
      chk("restart_count", 32'(rb_count), 32'd0);
      chk("restart_index", 32'(m_index), 32'd0);
      chk("restart_sb_empty", 32'(exp_q.size()), 32'd0);
      pulse_done();
      chk("restart_idle", 32'(rb_busy), 32'd0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
